// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Execute-issue register for the integer ALU; selects the operands,
//            builds the {funct3,funct7} opcode, and holds one valid/ready entry.
//            Optional writeback forwarding: define ALU_ISSUE_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    input  logic [WORDSIZE-1:0] rs1_data,
    input  logic [WORDSIZE-1:0] rs2_data,
    input  logic [WORDSIZE-1:0] imm,
    input  logic [WORDSIZE-1:0] pc,
    input  logic [4:0]          rd_in,
    input  logic                fwd_valid,
    input  logic [4:0]          fwd_rd,
    input  logic [WORDSIZE-1:0] fwd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] input_a,
    output logic [WORDSIZE-1:0] input_b,
    output logic [9:0]          operation,
    output logic [4:0]          rd_out,
    output logic                illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [9:0] c_OP_ADD = 10'b000_0000000;
    localparam logic [9:0] c_OP_SUB = 10'b000_0100000;

    localparam logic [WORDSIZE-1:0] c_FOUR = WORDSIZE'(4);

    localparam logic [1:0] c_SA_ZERO = 2'd0;
    localparam logic [1:0] c_SA_RS1  = 2'd1;
    localparam logic [1:0] c_SA_PC   = 2'd2;

    localparam logic [1:0] c_SB_ZERO = 2'd0;
    localparam logic [1:0] c_SB_RS2  = 2'd1;
    localparam logic [1:0] c_SB_IMM  = 2'd2;
    localparam logic [1:0] c_SB_FOUR = 2'd3;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [1:0]          w_sel_a;
    logic [1:0]          w_sel_b;
    logic [9:0]          w_op;
    logic                w_illegal;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_capture;
    logic                w_load;
    logic [WORDSIZE-1:0] w_rs1_val;
    logic [WORDSIZE-1:0] w_rs2_val;
    logic [WORDSIZE-1:0] w_a;
    logic [WORDSIZE-1:0] w_b;

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_capture = in_valid && in_ready;
    assign w_load    = w_capture && !flush;

    always_comb begin
        w_sel_a   = c_SA_ZERO;
        w_sel_b   = c_SB_ZERO;
        w_op      = c_OP_ADD;
        w_illegal = 1'b0;
        case (opcode)
            c_OPC_OP: begin
                w_sel_a = c_SA_RS1;
                w_sel_b = c_SB_RS2;
                w_op    = {funct3, funct7};
            end
            c_OPC_OPIMM: begin
                w_sel_a = c_SA_RS1;
                w_sel_b = c_SB_IMM;
                // Only the shift-right group carries meaning in funct7 (SRLI/SRAI)
                w_op    = (funct3 == 3'b101) ? {funct3, funct7} : {funct3, 7'b0};
            end
            c_OPC_LUI: begin
                w_sel_b = c_SB_IMM;
            end
            c_OPC_AUIPC: begin
                w_sel_a = c_SA_PC;
                w_sel_b = c_SB_IMM;
            end
            c_OPC_LOAD, c_OPC_STORE: begin
                w_sel_a = c_SA_RS1;
                w_sel_b = c_SB_IMM;
            end
            c_OPC_BRANCH: begin
                w_sel_a = c_SA_RS1;
                w_sel_b = c_SB_RS2;
                w_op    = c_OP_SUB;
            end
            c_OPC_JAL, c_OPC_JALR: begin
                w_sel_a = c_SA_PC;
                w_sel_b = c_SB_FOUR;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_use_rs1 = (w_sel_a == c_SA_RS1);
    assign w_use_rs2 = (w_sel_b == c_SB_RS2);

`ifdef ALU_ISSUE_FORWARD_EN
    logic [4:0] r_rs1_addr;
    logic [4:0] r_rs2_addr;
    logic       r_use_rs1;
    logic       r_use_rs2;
    logic       w_fwd_hit1;
    logic       w_fwd_hit2;
    logic       w_hold_fwd_a;
    logic       w_hold_fwd_b;
    logic       w_stalled;

    assign w_fwd_hit1   = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_addr);
    assign w_fwd_hit2   = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs2_addr);
    assign w_rs1_val    = w_fwd_hit1 ? fwd_data : rs1_data;
    assign w_rs2_val    = w_fwd_hit2 ? fwd_data : rs2_data;
    assign w_stalled    = out_valid && !out_ready && !flush;
    assign w_hold_fwd_a = w_stalled && r_use_rs1 && fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == r_rs1_addr);
    assign w_hold_fwd_b = w_stalled && r_use_rs2 && fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == r_rs2_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs1_addr <= 5'd0;
            r_rs2_addr <= 5'd0;
            r_use_rs1  <= 1'b0;
            r_use_rs2  <= 1'b0;
        end else if (w_load) begin
            r_rs1_addr <= rs1_addr;
            r_rs2_addr <= rs2_addr;
            r_use_rs1  <= w_use_rs1;
            r_use_rs2  <= w_use_rs2;
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr, rs2_addr, w_use_rs1, w_use_rs2};
    assign w_rs1_val    = rs1_data;
    assign w_rs2_val    = rs2_data;
`endif

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (w_sel_a)
            c_SA_RS1: w_a = w_rs1_val;
            c_SA_PC:  w_a = pc;
            default:  w_a = '0;
        endcase
        case (w_sel_b)
            c_SB_RS2:  w_b = w_rs2_val;
            c_SB_IMM:  w_b = imm;
            c_SB_FOUR: w_b = c_FOUR;
            default:   w_b = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_capture) w_state_nxt = S_FULL;
                S_FULL:  if (out_ready && !w_capture) w_state_nxt = S_EMPTY;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload is only rewritten by an accepted, unflushed capture
    always_ff @(posedge clk) begin
        if (reset) begin
            input_a   <= '0;
            input_b   <= '0;
            operation <= '0;
            rd_out    <= '0;
            illegal   <= 1'b0;
        end else if (w_load) begin
            input_a   <= w_a;
            input_b   <= w_b;
            operation <= w_op;
            rd_out    <= rd_in;
            illegal   <= w_illegal;
        end
`ifdef ALU_ISSUE_FORWARD_EN
        else begin
            if (w_hold_fwd_a) input_a <= fwd_data;
            if (w_hold_fwd_b) input_b <= fwd_data;
        end
`endif
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue pipeline register feeding the integer ALU (`alu_int_ar`). It accepts decoded RV64I instruction fields, selects the ALU operands and builds the 10-bit `{funct3, funct7}` operation code. It holds the result in a one-entry valid/ready register whose outputs drive the ALU inputs directly. It absorbs downstream stalls, supports pipeline flush and optionally applies writeback forwarding.

## Interface
- `WORDSIZE`, 64, datapath width; also the width of pc and imm.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `flush` input 1: discard the held entry and any same-cycle capture.
- `in_valid` input 1: upstream presents an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `opcode` input 7: RV opcode.
- `funct3` input 3: instruction funct3.
- `funct7` input 7: instruction funct7.
- `rs1_addr`, `rs2_addr` input 5 each: source register indices.
- `rs1_data`, `rs2_data` input WORDSIZE: register file read data.
- `imm` input WORDSIZE: sign-extended immediate.
- `pc` input WORDSIZE: instruction address.
- `rd_in` input 5: destination register.
- `fwd_valid` input 1: writeback result valid (used only with the macro).
- `fwd_rd` input 5: writeback destination (used only with the macro).
- `fwd_data` input WORDSIZE: writeback data (used only with the macro).
- `out_valid` output 1: held entry valid.
- `out_ready` input 1: downstream consumes the entry.
- `input_a`, `input_b` output WORDSIZE: ALU operands.
- `operation` output 10: ALU operation code.
- `rd_out` output 5: registered destination.
- `illegal` output 1: held entry has an unsupported opcode.

## Operation
- Operand and operation selection, applied at capture:
  - OP 0110011: a=rs1, b=rs2, op={funct3,funct7}.
  - OP-IMM 0010011: a=rs1, b=imm. op={funct3,7'b0}, except funct3=101, where op={funct3,funct7} (SRLI/SRAI).
  - LUI 0110111: a=0, b=imm, op=000_0000000.
  - AUIPC 0010111: a=pc, b=imm, op=add.
  - LOAD 0000011 and STORE 0100011: a=rs1, b=imm, op=add.
  - BRANCH 1100011: a=rs1, b=rs2, op=000_0100000 (sub).
  - JAL 1101111 and JALR 1100111: a=pc, b=4, op=add.
  - Any other opcode: a=0, b=0, op=0, `illegal`=1. The entry still flows normally.
- Handshake:
  - `in_ready = !out_valid || out_ready`, combinational.
  - Capture when `in_valid && in_ready`.
  - The entry is consumed when `out_valid && out_ready`.
  - Consume and capture in the same cycle: the new entry replaces the old one and `out_valid` stays 1.
  - While `out_valid && !out_ready`: outputs are held stable and upstream fields are ignored.
- Flush:
  - Next cycle `out_valid`=0, whatever `in_valid` or `out_ready` show.
  - `in_ready` is not gated by flush.
  - Flush wins over a simultaneous capture.
- `operation`, `input_a`, `input_b` and `rd_out` keep their last values when `out_valid`=0. The ALU output is don't-care then.
- Arithmetic: no arithmetic in this stage apart from the selection. The constant 4 is zero-extended to WORDSIZE.

## Timing
- Latency: 1 cycle from capture to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready`=1.
- Reset:
  - `out_valid`=0, `illegal`=0.
  - `input_a`=0, `input_b`=0, `operation`=0, `rd_out`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
- Reset has priority over flush and capture. Reset asserted mid-stall drops the held entry.
- State machine has two states:
  - EMPTY (`out_valid`=0) goes to FULL on capture without flush.
  - FULL stays FULL on a stall or on consume+capture.
  - FULL goes to EMPTY on consume without capture, or on flush.

## Configuration
- `ALU_ISSUE_FORWARD_EN` defined:
  - At capture, rs1 (rs2) data is replaced by `fwd_data` when `fwd_valid && fwd_rd==rs1_addr (rs2_addr) && fwd_rd!=0`. This applies only where that operand selects rs1 (rs2).
  - While FULL and stalled, a matching writeback updates the held `input_a`/`input_b` in place. This uses the stored rs1/rs2 indices and use flags.
  - rd=0 never forwards.
- `ALU_ISSUE_FORWARD_EN` undefined:
  - `fwd_*` are ignored.
  - No index or use-flag storage is built.
  - Operands come from `rs1_data`/`rs2_data` only.

## Test plan
- Reset, then ADD: opcode 0110011, f3=0, f7=0, rs1=5, rs2=7. Next cycle `out_valid`=1, a=5, b=7, operation=000_0000000.
- SUB then ADDI: SUB gives operation=000_0100000. ADDI with funct7 field garbage 0x7F and imm=-1 gives operation=000_0000000 and b=0xFFFF_FFFF_FFFF_FFFF.
- Stall: `out_ready`=0 for 3 cycles with new inputs applied. Outputs stay unchanged and `in_ready`=0. Raise `out_ready`: the next instruction is captured in the same cycle.
- Flush during FULL with `in_valid`=1. Next cycle `out_valid`=0. Opcode 0000000 gives `illegal`=1, a=b=0.
- AUIPC pc=0x1000, imm=0x2000 gives a=0x1000, b=0x2000, op add. JAL gives b=4.
- With macro: ADD rs1=x3 and `fwd_rd`=3, `fwd_data`=0xAA at capture gives a=0xAA. `fwd_rd`=0 does not forward. A stalled entry updates when a matching writeback arrives.
